// File: rtl/node_task_scheduler_pkg.sv
// Shared opcodes, FSM state encoding and op-word builder for the node scheduler.
package sched_pkg;

  localparam logic [3:0] OP_READY    = 4'h1;
  localparam logic [3:0] OP_SUSPEND  = 4'h2;
  localparam logic [3:0] OP_EXECUTE  = 4'h7;
  localparam logic [3:0] OP_KILL_ALL = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_RUN,
    ST_SUSP,
    ST_REQUEUE,
    ST_KILL,
    ST_HALT
  } sched_state_e;

  // Op word layout: {4'h0, id, opcode, arg}; arg is always zero.
  function automatic logic [15:0] mk_op(input logic [3:0] id, input logic [3:0] opcode);
    return {4'h0, id, opcode, 4'h0};
  endfunction

endpackage

// File: rtl/node_task_scheduler_if.sv
// Bundle between the task array / controller (master) and the scheduler (slave).
interface node_task_scheduler_if #(
  parameter int unsigned N_TASKS = 4,
  parameter int unsigned CNT_W   = 16
);
  logic                   en;
  logic [8*N_TASKS-1:0]   entries;
  logic                   task_done;
  logic                   kill_req;
  logic [15:0]            op_out;
  logic                   op_valid;
  logic                   busy;
  logic [3:0]             cur_id;
  logic                   halted;
  logic [CNT_W-1:0]       done_cnt;
  logic [CNT_W-1:0]       preempt_cnt;

  modport master (
    output en, entries, task_done, kill_req,
    input  op_out, op_valid, busy, cur_id, halted, done_cnt, preempt_cnt
  );

  modport slave (
    input  en, entries, task_done, kill_req,
    output op_out, op_valid, busy, cur_id, halted, done_cnt, preempt_cnt
  );
endinterface

// File: rtl/node_task_scheduler_prio_select.sv
// Combinational argmax over sorter entries; equal priorities resolve to the lowest slot.
module sched_prio_select
  import sched_pkg::*;
#(
  parameter int unsigned N_TASKS = 4
) (
  input  logic [8*N_TASKS-1:0] i_entries,
  output logic                 o_any_valid,
  output logic [3:0]           o_win_slot
);

  logic [3:0] w_best;

  // Strict '>' keeps the earlier (lower) slot on ties.
  always_comb begin
    o_any_valid = 1'b0;
    o_win_slot  = '0;
    w_best      = '0;
    for (int unsigned i = 0; i < N_TASKS; i++) begin
      if ((i_entries[8*i +: 8] != 8'h00) &&
          (!o_any_valid || (i_entries[8*i+4 +: 4] > w_best))) begin
        o_any_valid = 1'b1;
        o_win_slot  = 4'(i);
        w_best      = i_entries[8*i+4 +: 4];
      end
    end
  end

endmodule

// File: rtl/node_task_scheduler.sv
// Per-node task scheduler: selects the highest-priority Ready task, issues Execute,
// enforces a time quantum with Suspend/Ready preemption, and sequences a global kill.
module node_task_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned N_TASKS = 4,
  parameter int unsigned QUANTUM = 16,
  parameter int unsigned CNT_W   = 16
) (
  input logic                CLK,
  input logic                RST,
  node_task_scheduler_if.slave bus
);

  localparam int unsigned    QW     = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
  localparam logic [QW-1:0]  Q_LOAD = QW'(QUANTUM - 1);

  sched_state_e         r_state, w_state_nxt;
  logic [8*N_TASKS-1:0] r_snap;
  logic [QW-1:0]        r_q, w_q_nxt;
  logic [3:0]           r_kid, w_kid_nxt;
  logic [3:0]           r_cur, w_cur_nxt;
  logic [15:0]          r_op, w_op_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_busy, r_halted;
  logic [CNT_W-1:0]     r_done_cnt, r_pre_cnt;
  logic                 w_done_inc, w_pre_inc;
  logic                 w_any;
  logic [3:0]           w_slot, w_win_id;

  sched_prio_select #(.N_TASKS(N_TASKS)) u_sel (
    .i_entries  (r_snap),
    .o_any_valid(w_any),
    .o_win_slot (w_slot)
  );

  assign w_win_id = w_slot + 4'd1;

  // Next-state and next-output decode. Ops are computed for the state being entered
  // so they appear registered during that state's single cycle. The quantum counter
  // is loaded on entry to ISSUE, which makes Suspend land QUANTUM cycles after Execute.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = '0;
    w_valid_nxt = 1'b0;
    w_cur_nxt   = r_cur;
    w_kid_nxt   = r_kid;
    w_q_nxt     = (r_q != '0) ? r_q - QW'(1) : r_q;
    w_done_inc  = 1'b0;
    w_pre_inc   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.kill_req) begin
          w_state_nxt = ST_KILL;
          w_kid_nxt   = 4'd1;
          w_op_nxt    = mk_op(4'd1, OP_KILL_ALL);
          w_valid_nxt = 1'b1;
        end else if (bus.en && (bus.entries != '0)) begin
          w_state_nxt = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (w_any) begin
          w_state_nxt = ST_ISSUE;
          w_cur_nxt   = w_win_id;
          w_op_nxt    = mk_op(w_win_id, OP_EXECUTE);
          w_valid_nxt = 1'b1;
          w_q_nxt     = Q_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cur_nxt   = '0;
        end
      end
      ST_ISSUE: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.kill_req) begin
          w_state_nxt = ST_KILL;
          w_kid_nxt   = 4'd1;
          w_op_nxt    = mk_op(4'd1, OP_KILL_ALL);
          w_valid_nxt = 1'b1;
        end else if (bus.task_done) begin
          w_state_nxt = ST_IDLE;
          w_cur_nxt   = '0;
          w_done_inc  = 1'b1;
        end else if (r_q == '0) begin
          w_state_nxt = ST_SUSP;
          w_op_nxt    = mk_op(r_cur, OP_SUSPEND);
          w_valid_nxt = 1'b1;
          w_pre_inc   = 1'b1;
        end
      end
      ST_SUSP: begin
        w_state_nxt = ST_REQUEUE;
        w_op_nxt    = mk_op(r_cur, OP_READY);
        w_valid_nxt = 1'b1;
      end
      ST_REQUEUE: begin
        w_state_nxt = ST_IDLE;
        w_cur_nxt   = '0;
      end
      ST_KILL: begin
        if (r_kid == 4'(N_TASKS)) begin
          w_state_nxt = ST_HALT;
          w_cur_nxt   = '0;
        end else begin
          w_kid_nxt   = r_kid + 4'd1;
          w_op_nxt    = mk_op(r_kid + 4'd1, OP_KILL_ALL);
          w_valid_nxt = 1'b1;
        end
      end
      ST_HALT: w_cur_nxt = '0;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_snap   <= '0;
      r_q      <= '0;
      r_kid    <= '0;
      r_cur    <= '0;
      r_op     <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      if (r_state == ST_IDLE) r_snap <= bus.entries;
      r_q      <= w_q_nxt;
      r_kid    <= w_kid_nxt;
      r_cur    <= w_cur_nxt;
      r_op     <= w_op_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_HALT);
      r_halted <= (w_state_nxt == ST_HALT);
    end
  end

  // Statistics counters, wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done_cnt <= '0;
      r_pre_cnt  <= '0;
    end else begin
      if (w_done_inc) r_done_cnt <= r_done_cnt + CNT_W'(1);
      if (w_pre_inc)  r_pre_cnt  <= r_pre_cnt + CNT_W'(1);
    end
  end

  assign bus.op_out      = r_op;
  assign bus.op_valid    = r_valid;
  assign bus.busy        = r_busy;
  assign bus.cur_id      = r_cur;
  assign bus.halted      = r_halted;
  assign bus.done_cnt    = r_done_cnt;
  assign bus.preempt_cnt = r_pre_cnt;

endmodule

// File: tb/tb_node_task_scheduler.sv
// Directed bench for node_task_scheduler (N_TASKS=4, QUANTUM=16).
module tb_node_task_scheduler;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  node_task_scheduler_if #(.N_TASKS(4), .CNT_W(16)) bus ();

  node_task_scheduler #(.N_TASKS(4), .QUANTUM(16), .CNT_W(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_op_out"},   32'(bus.op_out), 32'h0);
    chk({tag, "_op_valid"}, 32'(bus.op_valid), 32'h0);
    chk({tag, "_busy"},     32'(bus.busy), 32'h0);
    chk({tag, "_cur_id"},   32'(bus.cur_id), 32'h0);
    chk({tag, "_halted"},   32'(bus.halted), 32'h0);
    chk({tag, "_done_cnt"}, 32'(bus.done_cnt), 32'h0);
    chk({tag, "_pre_cnt"},  32'(bus.preempt_cnt), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en        = 1'b0;
    bus.entries   = '0;
    bus.task_done = 1'b0;
    bus.kill_req  = 1'b0;

    // Reset state
    tick(); tick();
    RST = 1'b0;
    chk_reset_vals("reset");

    // Priority pick with tie between slot1 and slot2 -> id 2
    bus.entries = 32'h0070_7030;
    bus.en      = 1'b1;
    tick();
    chk("pick_select_valid", 32'(bus.op_valid), 32'h0);
    chk("pick_select_busy",  32'(bus.busy), 32'h1);
    bus.en      = 1'b0;
    bus.entries = '0;
    tick();
    chk("pick_exec_op",    32'(bus.op_out), 32'h0270);
    chk("pick_exec_valid", 32'(bus.op_valid), 32'h1);
    chk("pick_cur_id",     32'(bus.cur_id), 32'h2);

    // Completion on the 5th RUN cycle
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("run_quiet", 32'(bus.op_valid), 32'h0);
    end
    bus.task_done = 1'b1;
    tick();
    bus.task_done = 1'b0;
    chk("done_cnt1",   32'(bus.done_cnt), 32'h1);
    chk("done_busy",   32'(bus.busy), 32'h0);
    chk("done_valid",  32'(bus.op_valid), 32'h0);
    chk("done_precnt", 32'(bus.preempt_cnt), 32'h0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("done_no_susp", 32'(bus.op_valid), 32'h0);
    end

    // Preemption: slot0 only -> id 1
    bus.entries = 32'h0000_0051;
    bus.en      = 1'b1;
    tick();
    bus.en      = 1'b0;
    bus.entries = '0;
    tick();
    chk("pre_exec_op", 32'(bus.op_out), 32'h0170);
    chk("pre_cur_id",  32'(bus.cur_id), 32'h1);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("pre_run_quiet", 32'(bus.op_valid), 32'h0);
    end
    tick();
    chk("pre_susp_op",    32'(bus.op_out), 32'h0120);
    chk("pre_susp_valid", 32'(bus.op_valid), 32'h1);
    chk("pre_cnt1",       32'(bus.preempt_cnt), 32'h1);
    tick();
    chk("pre_ready_op",    32'(bus.op_out), 32'h0110);
    chk("pre_ready_valid", 32'(bus.op_valid), 32'h1);
    tick();
    chk("pre_after_valid", 32'(bus.op_valid), 32'h0);
    chk("pre_after_busy",  32'(bus.busy), 32'h0);

    // Done/expiry collision: slot1 -> id 2
    bus.entries = 32'h0000_2000;
    bus.en      = 1'b1;
    tick();
    bus.en      = 1'b0;
    bus.entries = '0;
    tick();
    chk("col_exec_op", 32'(bus.op_out), 32'h0270);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("col_run_quiet", 32'(bus.op_valid), 32'h0);
    end
    bus.task_done = 1'b1;
    tick();
    bus.task_done = 1'b0;
    chk("col_valid",    32'(bus.op_valid), 32'h0);
    chk("col_done_cnt", 32'(bus.done_cnt), 32'h2);
    chk("col_pre_cnt",  32'(bus.preempt_cnt), 32'h1);
    chk("col_busy",     32'(bus.busy), 32'h0);
    tick();
    chk("col_no_susp",  32'(bus.op_valid), 32'h0);

    // Reset mid-run: slot3 -> id 4
    bus.entries = 32'h9300_0000;
    bus.en      = 1'b1;
    tick();
    bus.en      = 1'b0;
    tick();
    chk("rst_exec_op", 32'(bus.op_out), 32'h0470);
    tick(); tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_reset_vals("midrst");

    // Re-selection after reset
    bus.en = 1'b1;
    tick();
    bus.en      = 1'b0;
    bus.entries = '0;
    tick();
    chk("resel_exec_op", 32'(bus.op_out), 32'h0470);
    chk("resel_cur_id",  32'(bus.cur_id), 32'h4);

    // Kill from mid-RUN
    tick(); tick(); tick();
    bus.kill_req = 1'b1;
    tick();
    chk("kill_op1", 32'(bus.op_out), 32'h01C0);
    chk("kill_v1",  32'(bus.op_valid), 32'h1);
    tick();
    chk("kill_op2", 32'(bus.op_out), 32'h02C0);
    chk("kill_v2",  32'(bus.op_valid), 32'h1);
    tick();
    chk("kill_op3", 32'(bus.op_out), 32'h03C0);
    tick();
    chk("kill_op4", 32'(bus.op_out), 32'h04C0);
    chk("kill_v4",  32'(bus.op_valid), 32'h1);
    tick();
    chk("halt_flag",   32'(bus.halted), 32'h1);
    chk("halt_valid",  32'(bus.op_valid), 32'h0);
    chk("halt_busy",   32'(bus.busy), 32'h0);
    chk("halt_cur_id", 32'(bus.cur_id), 32'h0);
    bus.kill_req = 1'b0;

    // HALT is sticky
    bus.entries = 32'h0000_00F1;
    bus.en      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("halt_sticky",  32'(bus.halted), 32'h1);
      chk("halt_no_op",   32'(bus.op_valid), 32'h0);
      chk("halt_no_busy", 32'(bus.busy), 32'h0);
    end
    chk("halt_done_cnt", 32'(bus.done_cnt), 32'h0);

    // Reset leaves HALT
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.en      = 1'b0;
    bus.entries = '0;
    chk_reset_vals("final_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
